sec_mux2_arbiter: RTL
=====================

SEC_MUX2_ARBITER -- requirements
Module: sec_mux2_arbiter

Interface
REQ-001 SHALL have parameter p_nbits, default 32, message width in bits.
REQ-002 SHALL have parameter p_slot, default 4, owner slot length in cycles in TDM mode, legal range 1..255.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports in0_val / in0_rdy / in0_msg: input 1 / output 1 / input p_nbits; requester 0 channel.
REQ-006 SHALL have ports in1_val / in1_rdy / in1_msg: input 1 / output 1 / input p_nbits; requester 1 channel.
REQ-007 SHALL have ports dom0 and dom1, input, 2 each, security domain labels of requesters 0 and 1.
REQ-008 SHALL have ports out_val / out_rdy / out_msg: output 1 / input 1 / output p_nbits; shared output channel.
REQ-009 SHALL have port sel, output, 1, registered owner select, 0 = requester 0; drives the shared 2-input mux select.
REQ-010 SHALL have port out_domain, output, 2, security domain label of the current out_msg.

Function
REQ-011 SHALL implement a 4-state FSM: OWN0, SCRUB01, OWN1, SCRUB10.
REQ-012 SHALL complete a transfer on a channel only in a cycle with val and rdy both high.
REQ-013 In OWNx: out_val = inx_val, inx_rdy = out_rdy, other rdy = 0, out_msg = inx_msg, out_domain = domx, sel = x.
REQ-014 In SCRUBxy: out_val = 0, in0_rdy = in1_rdy = 0, out_msg = all zeros, out_domain = domy, sel = y.
REQ-015 SHALL leave SCRUBxy for OWNy after exactly one cycle.
REQ-016 SHALL skip SCRUB when dom0 == dom1 at the switch decision, going OWNx -> OWNy directly.
REQ-017 Work-conserving mode: SHALL switch OWNx -> other when other val = 1 and (inx_val = 0 or inx transfer this cycle); otherwise stay.
REQ-018 SHALL hold at most one transfer per grant when both requesters are continuously valid.
REQ-019 SHALL keep out_msg stable while out_val = 1 and out_rdy = 0; no switch occurs without a transfer or idle owner.
REQ-020 SHALL add no latency on the data path; out_msg is combinational from the owner's msg.
REQ-021 SHALL treat X on the non-owner's val and msg as don't-care; such X SHALL not propagate to outputs.

Reset
REQ-022 While reset = 1: in0_rdy = in1_rdy = out_val = 0, out_msg = 0, and no transfer completes.
REQ-023 On the first edge with reset = 1: state = OWN0, sel = 0, slot counter = 0.
REQ-024 Reset asserted mid-slot or mid-scrub SHALL abort it; no carry-over to the post-reset state.

Configuration
REQ-025 Macro SEC_ARB_TDM_EN SHALL select the switching policy at compile time.
REQ-026 With SEC_ARB_TDM_EN defined: OWNx SHALL last exactly p_slot cycles independent of val, rdy, and transfers.
REQ-027 With SEC_ARB_TDM_EN defined: the 8-bit slot counter SHALL clear on entry to OWNx and stay frozen in SCRUB.
REQ-028 With SEC_ARB_TDM_EN defined: a transfer in the last slot cycle SHALL be valid.
REQ-029 With SEC_ARB_TDM_EN defined: p_slot = 1 SHALL alternate owners every cycle (plus any scrub cycles).
REQ-030 Without SEC_ARB_TDM_EN: policy SHALL be per REQ-017, and no slot counter SHALL be instantiated.

Verification
REQ-031 Reset, then idle inputs -> sel=0, out_val=0, in0_rdy=out_rdy, in1_rdy=0 every cycle.
REQ-032 Work-conserving mode; both val=1, dom0=0, dom1=3, out_rdy=1 -> transfers alternate 0, 1, 0, 1, each separated by one scrub cycle with out_msg=0 and out_domain=3 then 0.
REQ-033 Same as REQ-032 with dom0 = dom1 = 1 -> alternating transfers every cycle, no scrub.
REQ-034 TDM mode, p_slot=4, only in0_val=1, dom0=0, dom1=2 -> pattern of 4 cycles OWN0, 1 scrub, 4 cycles OWN1 with in0_rdy=0, 1 scrub; sel period 10 cycles.
REQ-035 Hold out_rdy=0 with in0 owning and in1_val=1 (work-conserving) -> sel stays 0, out_msg equals in0_msg, no switch until out_rdy=1 completes the transfer.
REQ-036 Assert reset for 1 cycle during SCRUB01 -> next cycle state OWN0, sel=0; during reset, out_val=0 and in0_rdy=in1_rdy=0.

Source files
------------

// File: rtl/sec_mux2_arbiter.sv
// sec_mux2_arbiter: two-requester arbiter feeding a shared output channel,
// with a one-cycle scrub bubble whenever ownership passes between requesters
// that carry different security domain labels. The data path is purely
// combinational from the owning requester; only the owner state is registered.
// Compile-time option: define SEC_ARB_TDM_EN to replace the work-conserving
// switch policy with fixed time slots of p_slot cycles per owner.
module sec_mux2_arbiter #(
    parameter int p_nbits = 32,
    parameter int p_slot  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in0_val,
    output logic               in0_rdy,
    input  logic [p_nbits-1:0] in0_msg,
    input  logic               in1_val,
    output logic               in1_rdy,
    input  logic [p_nbits-1:0] in1_msg,
    input  logic [1:0]         dom0,
    input  logic [1:0]         dom1,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic               sel,
    output logic [1:0]         out_domain
);

    typedef enum logic [1:0] {
        OWN0    = 2'd0,
        SCRUB01 = 2'd1,
        OWN1    = 2'd2,
        SCRUB10 = 2'd3
    } state_t;

    state_t state;
    logic   switch_now;
    logic   same_dom;

    // Equal labels mean no information can leak across the handover.
    assign same_dom = (dom0 == dom1);

`ifdef SEC_ARB_TDM_EN
    if (p_slot < 1 || p_slot > 255) begin : g_bad_slot
        $error("p_slot must be in 1..255");
    end

    localparam logic [7:0] SLOT_LAST = 8'(p_slot - 1);

    logic [7:0] slot_cnt;

    // Fixed slots: the owner is released on the last cycle of its slot only.
    always_comb begin
        switch_now = 1'b0;
        if (state == OWN0 || state == OWN1) begin
            switch_now = (slot_cnt == SLOT_LAST);
        end
    end

    // Slot counter: counts owner cycles, clears when leaving an owner state
    // (so every owner state starts at zero) and holds through scrub.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= 8'd0;
        end else if (state == OWN0 || state == OWN1) begin
            if (switch_now) begin
                slot_cnt <= 8'd0;
            end else begin
                slot_cnt <= slot_cnt + 8'd1;
            end
        end
    end
`else
    // Work-conserving: hand over when the other side is waiting and the
    // owner is either idle or completing its transfer in this cycle.
    always_comb begin
        switch_now = 1'b0;
        unique case (state)
            OWN0:    switch_now = in1_val && (!in0_val || out_rdy);
            OWN1:    switch_now = in0_val && (!in1_val || out_rdy);
            default: switch_now = 1'b0;
        endcase
    end
`endif

    // Owner FSM with registered mux select; scrub always lasts one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OWN0;
            sel   <= 1'b0;
        end else begin
            unique case (state)
                OWN0: begin
                    if (switch_now) begin
                        state <= same_dom ? OWN1 : SCRUB01;
                        sel   <= 1'b1;
                    end
                end
                SCRUB01: begin
                    state <= OWN1;
                    sel   <= 1'b1;
                end
                OWN1: begin
                    if (switch_now) begin
                        state <= same_dom ? OWN0 : SCRUB10;
                        sel   <= 1'b0;
                    end
                end
                SCRUB10: begin
                    state <= OWN0;
                    sel   <= 1'b0;
                end
            endcase
        end
    end

    // Data path and handshakes: only the owner's signals reach the outputs,
    // scrub drives an all-zero bubble labelled with the incoming domain,
    // and reset blocks every handshake.
    always_comb begin
        out_val    = 1'b0;
        in0_rdy    = 1'b0;
        in1_rdy    = 1'b0;
        out_msg    = '0;
        out_domain = dom0;
        unique case (state)
            OWN0: begin
                out_val    = in0_val;
                in0_rdy    = out_rdy;
                out_msg    = in0_msg;
                out_domain = dom0;
            end
            SCRUB01: begin
                out_domain = dom1;
            end
            OWN1: begin
                out_val    = in1_val;
                in1_rdy    = out_rdy;
                out_msg    = in1_msg;
                out_domain = dom1;
            end
            SCRUB10: begin
                out_domain = dom0;
            end
        endcase
        if (reset) begin
            out_val = 1'b0;
            in0_rdy = 1'b0;
            in1_rdy = 1'b0;
            out_msg = '0;
        end
    end

endmodule
